// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-4 Booth multiplier.
// Retires one Booth digit per clock and returns the full 2*WIDTH-bit product
// for either signed or unsigned operands, chosen per operation.
// Handshake: start is accepted from IDLE only. busy covers CALC and DONE.
// done is a one-cycle pulse, and product holds until the next DONE or reset.
module booth_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Number of radix-4 digits: the multiplier is widened by two bits so
    // that an unsigned operand keeps a zero sign position.
    localparam int N  = WIDTH / 2 + 1;
    localparam int AW = 2 * WIDTH + 2;   // accumulator / shifted multiplicand
    localparam int QW = WIDTH + 2;       // extended multiplier
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);
    localparam logic [AW-1:0] ONE        = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   acc_reg;
    logic [AW-1:0]   mcand_reg;     // multiplicand pre-shifted by 4^i
    logic [QW-1:0]   mplier_reg;    // multiplier, consumed two bits per step
    logic            prev_bit_reg;  // b[2i-1] of the current digit
    logic [CW-1:0]   cnt_reg;

    // Operand extension: sign-extend in signed mode, zero-extend otherwise.
    logic            ext_a;
    logic            ext_b;
    wire  [AW-1:0]   a_ext;
    wire  [QW-1:0]   b_ext;

    assign ext_a = is_signed & a[WIDTH-1];
    assign ext_b = is_signed & b[WIDTH-1];

    assign a_ext[WIDTH-1:0] = a;
    assign b_ext[WIDTH-1:0] = b;

    for (genvar gi = WIDTH; gi < AW; gi++) begin : g_a_ext
        assign a_ext[gi] = ext_a;
    end

    for (genvar gi = WIDTH; gi < QW; gi++) begin : g_b_ext
        assign b_ext[gi] = ext_b;
    end

    // Booth digit selection. The multiplicand register already carries the
    // 4^i weight, so the addend is simply 0, +-A or +-2A of it.
    logic [2:0]      digit_bits;
    logic [AW-1:0]   mcand_x2;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   acc_next;

    assign digit_bits = {mplier_reg[1:0], prev_bit_reg};
    assign mcand_x2   = {mcand_reg[AW-2:0], 1'b0};

    // Recode the current digit into the value to accumulate (negation is invert + 1).
    always_comb begin
        addend = '0;
        case (digit_bits)
            3'b001, 3'b010: addend = mcand_reg;
            3'b011:         addend = mcand_x2;
            3'b100:         addend = ~mcand_x2 + ONE;
            3'b101, 3'b110: addend = ~mcand_reg + ONE;
            default:        addend = '0;
        endcase
    end

    assign acc_next = acc_reg + addend;

    // Control FSM and datapath. Shifting the multiplicand left instead of the
    // accumulator right gives the same sum modulo 2^AW with a fixed-position product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            product      <= '0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            prev_bit_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_reg    <= a_ext;
                        mplier_reg   <= b_ext;
                        prev_bit_reg <= 1'b0;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        busy         <= 1'b1;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    acc_reg      <= acc_next;
                    mcand_reg    <= {mcand_reg[AW-3:0], 2'b00};
                    mplier_reg   <= {2'b00, mplier_reg[QW-1:2]};
                    prev_bit_reg <= mplier_reg[1];
                    cnt_reg      <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_DIGIT) begin
                        product   <= acc_next[2*WIDTH-1:0];
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: three multipliers (WIDTH 8, 16, 32) driven by one
// stimulus process. Expected results are queued per instance when a start
// is issued, and a negedge monitor pops and compares on every done pulse.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  start_v = '0;
    logic [2:0]  sgn_v   = '0;
    logic [2:0]  rst_v   = '1;
    logic [31:0] a_v [3] = '{default: '0};
    logic [31:0] b_v [3] = '{default: '0};

    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [15:0] p8;
    wire  [31:0] p16;
    wire  [63:0] p32;

    booth_mult_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .is_signed(sgn_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .product(p8)
    );

    booth_mult_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .is_signed(sgn_v[1]),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]),
        .busy(busy_v[1]), .done(done_v[1]), .product(p16)
    );

    booth_mult_seq #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .is_signed(sgn_v[2]),
        .a(a_v[2]), .b(b_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .product(p32)
    );

    // Posedge counter and the reset value each DUT saw at its last edge.
    int         cyc = 0;
    logic [2:0] rst_q = '0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_v;
    end

    typedef struct {
        logic [63:0] prod;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        int          acc_edge;   // index of the posedge that accepts the start
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_prod [3] = '{default: '0};
    int          wait_cnt  [3] = '{default: 0};

    function automatic int w_of(int d);
        return (d == 0) ? 8 : (d == 1) ? 16 : 32;
    endfunction

    function automatic logic [63:0] prod_of(int d);
        case (d)
            0:       return {48'd0, p8};
            1:       return {32'd0, p16};
            default: return p32;
        endcase
    endfunction

    function automatic void q_push(int d, exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_pop(int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_flush(int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Reference model: interpret both operands as w-bit numbers (two's
    // complement when signed) and multiply with plain integer arithmetic.
    function automatic logic [63:0] model(int w, bit sgn, logic [31:0] a, logic [31:0] b);
        logic [31:0] m32;
        logic [63:0] m64;
        longint      x;
        longint      y;
        longint      p;
        m32 = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        m64 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        x = longint'(a & m32);
        y = longint'(b & m32);
        if (sgn && a[w-1]) x = x - (longint'(1) << w);
        if (sgn && b[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return 64'(p) & m64;
    endfunction

    function automatic logic [31:0] pick(int w);
        logic [31:0] one_hot;
        one_hot = 32'd1 << (w - 1);
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return one_hot;
            3:       return one_hot - 32'd1;
            4:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: reset state, result and latency on done, product hold, timeouts.
    always @(negedge clk) begin : monitor
        logic [63:0] p;
        exp_t        e;
        int          lat;
        int          w;
        for (int d = 0; d < 3; d++) begin
            p = prod_of(d);
            w = w_of(d);
            if (rst_q[d]) begin
                n_tests++;
                if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || p !== 64'd0) begin
                    n_fail++;
                    $display("FAIL reset_state w=%0d: busy=%b done=%b product=%h, required 0 0 0",
                             w, busy_v[d], done_v[d], p);
                end
                q_flush(d);
                last_prod[d] = '0;
                wait_cnt[d]  = 0;
            end else if (done_v[d] === 1'b1) begin
                wait_cnt[d] = 0;
                if (q_size(d) == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done w=%0d: product=%h with no operation pending", w, p);
                end else begin
                    e = q_pop(d);
                    // done is seen by the edge after the one that raised it.
                    lat = cyc + 1 - e.acc_edge;
                    n_tests++;
                    if (p !== e.prod) begin
                        n_fail++;
                        $display("FAIL product w=%0d s=%0d a=%h b=%h: got %h, required %h",
                                 w, e.sgn, e.a, e.b, p, e.prod);
                    end
                    n_tests++;
                    if (lat != w / 2 + 2) begin
                        n_fail++;
                        $display("FAIL latency w=%0d a=%h b=%h: got %0d, required %0d",
                                 w, e.a, e.b, lat, w / 2 + 2);
                    end
                    n_tests++;
                    if (busy_v[d] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_at_done w=%0d: got %b, required 1", w, busy_v[d]);
                    end
                    $display("[TB] w=%0d s=%0d a=%h b=%h product=%h lat=%0d",
                             w, e.sgn, e.a, e.b, p, lat);
                    last_prod[d] = e.prod;
                end
            end else begin
                n_tests++;
                if (p !== last_prod[d]) begin
                    n_fail++;
                    $display("FAIL product_held w=%0d: got %h, required %h", w, p, last_prod[d]);
                end
                if (q_size(d) != 0) begin
                    wait_cnt[d]++;
                    if (wait_cnt[d] > 40) begin
                        e = q_pop(d);
                        n_tests++;
                        n_fail++;
                        $display("FAIL timeout w=%0d a=%h b=%h: no done, required product %h",
                                 w, e.a, e.b, e.prod);
                        wait_cnt[d] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(int d);
        int g = 0;
        while (busy_v[d] !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            $display("FAIL busy_stuck w=%0d: busy=%b, required 0 within 100 cycles", w_of(d), busy_v[d]);
            $fatal(1, "busy never cleared");
        end
    endtask

    // Issue one operation from IDLE, then scramble the inputs after acceptance.
    task automatic issue(int d, bit sgn, logic [31:0] a, logic [31:0] b, logic [63:0] expv);
        exp_t e;
        wait_idle(d);
        sgn_v[d]   = sgn;
        a_v[d]     = a;
        b_v[d]     = b;
        start_v[d] = 1'b1;
        e.prod     = expv;
        e.a        = a;
        e.b        = b;
        e.sgn      = sgn;
        e.acc_edge = cyc + 1;
        q_push(d, e);
        @(negedge clk);
        start_v[d] = 1'b0;
        a_v[d]     = $urandom;
        b_v[d]     = $urandom;
        sgn_v[d]   = ~sgn;
    endtask

    task automatic random_ops(int d, bit sgn, int count);
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < count; i++) begin
            a = pick(w_of(d));
            b = pick(w_of(d));
            issue(d, sgn, a, b, model(w_of(d), sgn, a, b));
        end
    endtask

    initial begin : stimulus
        exp_t e;
        int   g;
        repeat (3) @(negedge clk);
        rst_v = '0;
        @(negedge clk);

        // Directed WIDTH=16 cases with hand-computed products.
        issue(1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001);
        issue(1, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_0000_0001);
        issue(1, 1'b1, 32'h0000_8000, 32'h0000_8000, 64'h0000_0000_4000_0000);
        issue(1, 1'b1, 32'h0000_FFFD, 32'h0000_0005, 64'h0000_0000_FFFF_FFF1);
        issue(1, 1'b0, 32'h0000_0000, 32'h0000_ABCD, 64'h0);

        // start held high for the whole op; operands change three cycles in.
        wait_idle(1);
        sgn_v[1]   = 1'b1;
        a_v[1]     = 32'h0000_FFF0;
        b_v[1]     = 32'h0000_0101;
        start_v[1] = 1'b1;
        e.prod = 64'h0000_0000_FFFF_EFF0; e.a = a_v[1]; e.b = b_v[1]; e.sgn = 1'b1;
        e.acc_edge = cyc + 1;
        q_push(1, e);
        repeat (3) @(negedge clk);
        a_v[1] = 32'h0000_7FFF;
        b_v[1] = 32'h0000_7FFF;
        // The still-high start is next accepted 11 edges after the first.
        e.prod = 64'h0000_0000_3FFF_0001; e.a = a_v[1]; e.b = b_v[1]; e.sgn = 1'b1;
        e.acc_edge = e.acc_edge + 11;
        q_push(1, e);
        repeat (9) @(negedge clk);
        start_v[1] = 1'b0;

        // Reset four edges into CALC aborts the operation.
        issue(1, 1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
        repeat (3) @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        repeat (15) @(negedge clk);
        issue(1, 1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);

        // start together with rst: nothing may be accepted.
        wait_idle(1);
        start_v[1] = 1'b1;
        rst_v[1]   = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        rst_v[1]   = 1'b0;
        repeat (15) @(negedge clk);

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          s;
            a = pick(16);
            b = pick(16);
            s = bit'($urandom_range(0, 1));
            issue(1, s, a, b, model(16, s, a, b));
        end
        random_ops(0, 1'b0, 1000);
        random_ops(0, 1'b1, 1000);
        random_ops(2, 1'b0, 1000);
        random_ops(2, 1'b1, 1000);

        g = 0;
        while ((q_size(0) + q_size(1) + q_size(2)) != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
